uart_fifo_param: RTL and testbench

Parametrised full-duplex UART and the next generation of the existing fixed 8N1 UART. It has configurable data width, parity mode and stop-bit count, a 16x oversampled receiver, and synchronous FIFOs on both TX and RX paths. It sits between a host-side read/write strobe interface and the serial pins. It replaces the fixed-rate, single-byte-buffer UART top.

---
 rtl/uart_fifo_param.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_uart_fifo_param.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_param.sv
// Parametrised full-duplex UART with 16x oversampled receiver and synchronous
// TX/RX FIFOs between a host strobe interface and the serial pins.
module uart_fifo_param #(
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int CLKS_PER_TICK = 27,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_empty,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [TW-1:0] LP_TICK_LAST = TW'(CLKS_PER_TICK - 1);
  localparam logic [3:0]    LP_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LP_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Parity bit that the frame must carry for the configured mode.
  function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  assign w_tick = (r_tick_cnt == LP_TICK_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_tick_cnt <= '0;
    else        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
  end

  logic [DATA_BITS-1:0] r_txf_mem [FIFO_DEPTH];
  logic [AW:0]          r_txf_wp, r_txf_rp;
  logic                 w_txf_empty, w_txf_push, w_txf_pop;
  logic [DATA_BITS-1:0] w_txf_head;

  assign w_txf_empty = (r_txf_wp == r_txf_rp);
  assign tx_full     = (r_txf_wp[AW] != r_txf_rp[AW]) &&
                       (r_txf_wp[AW-1:0] == r_txf_rp[AW-1:0]);
  assign w_txf_push  = wr_en && !tx_full;
  assign w_txf_head  = r_txf_mem[r_txf_rp[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (w_txf_push) r_txf_mem[r_txf_wp[AW-1:0]] <= din;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_txf_wp <= '0;
      r_txf_rp <= '0;
    end else begin
      if (w_txf_push) r_txf_wp <= r_txf_wp + 1'b1;
      if (w_txf_pop)  r_txf_rp <= r_txf_rp + 1'b1;
    end
  end

  state_t               r_tx_state, w_tx_state_nx;
  logic [3:0]           r_tx_tcnt, w_tx_tcnt_nx, r_tx_bcnt, w_tx_bcnt_nx;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nx;
  logic                 r_tx_par, w_tx_par_nx, r_tx, w_tx_nx, w_tx_end, w_tx_load;

  assign w_tx_end = w_tick && (r_tx_tcnt == 4'd15);

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_tcnt_nx  = (w_tick && r_tx_state != S_IDLE) ? r_tx_tcnt + 4'd1 : r_tx_tcnt;
    w_tx_bcnt_nx  = r_tx_bcnt;
    w_tx_shift_nx = r_tx_shift;
    w_tx_par_nx   = r_tx_par;
    w_tx_load     = 1'b0;
    w_txf_pop     = 1'b0;
    case (r_tx_state)
      S_IDLE:  if (w_tick && !w_txf_empty) w_tx_load = 1'b1;
      S_START: if (w_tx_end) begin
        w_tx_state_nx = S_DATA;
        w_tx_bcnt_nx  = 4'd0;
      end
      S_DATA: if (w_tx_end) begin
        if (r_tx_bcnt == LP_DATA_LAST) begin
          w_tx_bcnt_nx  = 4'd0;
          w_tx_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          w_tx_bcnt_nx  = r_tx_bcnt + 4'd1;
          w_tx_shift_nx = {1'b0, r_tx_shift[DATA_BITS-1:1]};
        end
      end
      S_PARITY: if (w_tx_end) begin
        w_tx_state_nx = S_STOP;
        w_tx_bcnt_nx  = 4'd0;
      end
      S_STOP: if (w_tx_end) begin
        if (r_tx_bcnt == LP_STOP_LAST) begin
          // Chain straight into the next frame when more data is queued.
          if (!w_txf_empty) w_tx_load = 1'b1;
          else              w_tx_state_nx = S_IDLE;
        end else begin
          w_tx_bcnt_nx = r_tx_bcnt + 4'd1;
        end
      end
      default: w_tx_state_nx = S_IDLE;
    endcase
    if (w_tx_load) begin
      w_txf_pop     = 1'b1;
      w_tx_state_nx = S_START;
      w_tx_shift_nx = w_txf_head;
      w_tx_par_nx   = f_parity(w_txf_head);
      w_tx_tcnt_nx  = 4'd0;
      w_tx_bcnt_nx  = 4'd0;
    end
    case (w_tx_state_nx)
      S_START:  w_tx_nx = 1'b0;
      S_DATA:   w_tx_nx = w_tx_shift_nx[0];
      S_PARITY: w_tx_nx = w_tx_par_nx;
      default:  w_tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tx_state <= S_IDLE;
      r_tx_tcnt  <= 4'd0;
      r_tx_bcnt  <= 4'd0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_tcnt  <= w_tx_tcnt_nx;
      r_tx_bcnt  <= w_tx_bcnt_nx;
      r_tx       <= w_tx_nx;
    end
  end

  always_ff @(posedge CLK) begin
    r_tx_shift <= w_tx_shift_nx;
    r_tx_par   <= w_tx_par_nx;
  end

  assign tx      = r_tx;
  assign tx_busy = !w_txf_empty || (r_tx_state != S_IDLE);

  logic r_rx_s1, r_rx_s2, r_rx_prev;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      if (w_tick) r_rx_prev <= r_rx_s2;
    end
  end

  state_t               r_rx_state, w_rx_state_nx;
  logic [3:0]           r_rx_tcnt, w_rx_tcnt_nx, r_rx_bcnt, w_rx_bcnt_nx;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nx;
  logic                 w_rx_mid, w_rx_push, w_set_perr, w_set_ferr, w_set_ovr;

  // The start bit is checked half a bit in; every later bit a full bit on.
  assign w_rx_mid = w_tick && ((r_rx_state == S_START) ? (r_rx_tcnt == 4'd7)
                                                        : (r_rx_tcnt == 4'd15));

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_tcnt_nx  = (w_tick && r_rx_state != S_IDLE) ? r_rx_tcnt + 4'd1 : r_rx_tcnt;
    w_rx_bcnt_nx  = r_rx_bcnt;
    w_rx_shift_nx = r_rx_shift;
    w_rx_push     = 1'b0;
    w_set_perr    = 1'b0;
    w_set_ferr    = 1'b0;
    case (r_rx_state)
      S_IDLE: if (w_tick && r_rx_prev && !r_rx_s2) begin
        w_rx_state_nx = S_START;
        w_rx_tcnt_nx  = 4'd0;
      end
      S_START: if (w_rx_mid) begin
        w_rx_state_nx = r_rx_s2 ? S_IDLE : S_DATA;
        w_rx_tcnt_nx  = 4'd0;
        w_rx_bcnt_nx  = 4'd0;
      end
      S_DATA: if (w_rx_mid) begin
        w_rx_shift_nx = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
        w_rx_tcnt_nx  = 4'd0;
        if (r_rx_bcnt == LP_DATA_LAST) begin
          w_rx_bcnt_nx  = 4'd0;
          w_rx_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          w_rx_bcnt_nx = r_rx_bcnt + 4'd1;
        end
      end
      S_PARITY: if (w_rx_mid) begin
        w_set_perr    = (r_rx_s2 != f_parity(r_rx_shift));
        w_rx_state_nx = S_STOP;
        w_rx_tcnt_nx  = 4'd0;
      end
      S_STOP: if (w_rx_mid) begin
        w_rx_push     = 1'b1;
        w_set_ferr    = !r_rx_s2;
        w_rx_state_nx = S_IDLE;
        w_rx_tcnt_nx  = 4'd0;
      end
      default: w_rx_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rx_state <= S_IDLE;
      r_rx_tcnt  <= 4'd0;
      r_rx_bcnt  <= 4'd0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_rx_tcnt  <= w_rx_tcnt_nx;
      r_rx_bcnt  <= w_rx_bcnt_nx;
    end
  end

  always_ff @(posedge CLK) r_rx_shift <= w_rx_shift_nx;

  logic [DATA_BITS-1:0] r_rxf_mem [FIFO_DEPTH];
  logic [AW:0]          r_rxf_wp, r_rxf_rp;
  logic                 w_rxf_full, w_rxf_wr, w_rxf_pop;

  assign rx_empty   = (r_rxf_wp == r_rxf_rp);
  assign w_rxf_full = (r_rxf_wp[AW] != r_rxf_rp[AW]) &&
                      (r_rxf_wp[AW-1:0] == r_rxf_rp[AW-1:0]);
  assign w_rxf_wr   = w_rx_push && !w_rxf_full;
  assign w_set_ovr  = w_rx_push && w_rxf_full;
  assign w_rxf_pop  = rd_en && !rx_empty;
  assign dout       = r_rxf_mem[r_rxf_rp[AW-1:0]];

  // Storage is cleared so the fall-through head reads zero out of reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_rxf_mem[i] <= '0;
      r_rxf_wp <= '0;
      r_rxf_rp <= '0;
    end else begin
      if (w_rxf_wr) begin
        r_rxf_mem[r_rxf_wp[AW-1:0]] <= r_rx_shift;
        r_rxf_wp <= r_rxf_wp + 1'b1;
      end
      if (w_rxf_pop) r_rxf_rp <= r_rxf_rp + 1'b1;
    end
  end

  logic r_perr, r_ferr, r_ovr;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_set_perr)   r_perr <= 1'b1;
      else if (err_clr) r_perr <= 1'b0;
      if (w_set_ferr)   r_ferr <= 1'b1;
      else if (err_clr) r_ferr <= 1'b0;
      if (w_set_ovr)    r_ovr  <= 1'b1;
      else if (err_clr) r_ovr  <= 1'b0;
    end
  end

  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Bench for uart_fifo_param: an 8N1 instance in loopback and an odd-parity,
// 2-stop, depth-4 instance whose receiver can also be driven directly.
module tb_uart_fifo_param;
  localparam int CPT = 4;
  localparam int BIT = 16 * CPT;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic [7:0] din_a, dout_a, din_b, dout_b;
  logic wr_en_a, tx_full_a, tx_busy_a, tx_a, rx_a, rd_en_a, rx_empty_a;
  logic perr_a, ferr_a, ovr_a, err_clr_a;
  logic wr_en_b, tx_full_b, tx_busy_b, tx_b, rx_b, rd_en_b, rx_empty_b;
  logic perr_b, ferr_b, ovr_b, err_clr_b;
  logic loop_b, rx_drv_b;

  assign rx_a = tx_a;
  assign rx_b = loop_b ? tx_b : rx_drv_b;

  uart_fifo_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .CLKS_PER_TICK(CPT), .FIFO_DEPTH(16)) u_a (
    .CLK(CLK), .RST_N(RST_N), .din(din_a), .wr_en(wr_en_a), .tx_full(tx_full_a),
    .tx_busy(tx_busy_a), .tx(tx_a), .rx(rx_a), .rd_en(rd_en_a), .dout(dout_a),
    .rx_empty(rx_empty_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun(ovr_a), .err_clr(err_clr_a));

  uart_fifo_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
                    .CLKS_PER_TICK(CPT), .FIFO_DEPTH(4)) u_b (
    .CLK(CLK), .RST_N(RST_N), .din(din_b), .wr_en(wr_en_b), .tx_full(tx_full_b),
    .tx_busy(tx_busy_b), .tx(tx_b), .rx(rx_b), .rd_en(rd_en_b), .dout(dout_b),
    .rx_empty(rx_empty_b), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun(ovr_b), .err_clr(err_clr_b));

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q_txa[$], q_txb[$], q_rxa[$], q_rxb[$];
  int gen_b = 0;
  bit mon_en_b = 1'b1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not as expected at %0t", name, $time);
  endtask

  function automatic logic get_tx(input int w);    return (w == 0) ? tx_a : tx_b;             endfunction
  function automatic logic get_empty(input int w); return (w == 0) ? rx_empty_a : rx_empty_b; endfunction
  function automatic logic [7:0] get_dout(input int w); return (w == 0) ? dout_a : dout_b;    endfunction
  function automatic int qsize_tx(input int w); return (w == 0) ? q_txa.size() : q_txb.size(); endfunction
  function automatic int qsize_rx(input int w); return (w == 0) ? q_rxa.size() : q_rxb.size(); endfunction
  function automatic logic [7:0] qpop_tx(input int w);
    if (w == 0) return q_txa.pop_front();
    return q_txb.pop_front();
  endfunction
  function automatic logic [7:0] qpop_rx(input int w);
    if (w == 0) return q_rxa.pop_front();
    return q_rxb.pop_front();
  endfunction

  // Decodes frames off the serial pin by mid-bit sampling.
  task automatic mon_tx(input int w);
    forever begin
      logic [7:0] d, e;
      logic p, ok;
      int g;
      @(negedge CLK);
      if (get_tx(w) == 1'b0) begin
        g = gen_b;
        p = 1'b0;
        repeat (BIT / 2) @(negedge CLK);
        ok = (get_tx(w) == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge CLK);
          d[i] = get_tx(w);
        end
        if (w == 1) begin
          repeat (BIT) @(negedge CLK);
          p = get_tx(w);
        end
        for (int s = 0; s < ((w == 0) ? 1 : 2); s++) begin
          repeat (BIT) @(negedge CLK);
          ok = ok && (get_tx(w) == 1'b1);
        end
        if (w == 0 || g == gen_b) begin
          if (qsize_tx(w) == 0) fail("tx_unexpected_frame");
          else begin
            e = qpop_tx(w);
            chk("tx_data", d, e);
            if (w == 1) chk1("tx_parity", p, ~(^e));
            chk1("tx_framing", ok, 1'b1);
          end
        end
      end
    end
  endtask

  // Pops the RX FIFO whenever it holds data and compares against the model.
  task automatic mon_rx(input int w);
    forever begin
      @(negedge CLK);
      if (w == 0) rd_en_a = 1'b0; else rd_en_b = 1'b0;
      if ((w == 0 || mon_en_b) && get_empty(w) == 1'b0 && $urandom_range(0, 3) != 0) begin
        if (qsize_rx(w) == 0) fail("rx_unexpected_word");
        else chk("rx_data", get_dout(w), qpop_rx(w));
        if (w == 0) rd_en_a = 1'b1; else rd_en_b = 1'b1;
      end
    end
  endtask

  initial mon_tx(0);
  initial mon_tx(1);
  initial mon_rx(0);
  initial mon_rx(1);

  task automatic wr(input int w, input logic [7:0] d);
    @(negedge CLK);
    if (w == 0) begin din_a = d; wr_en_a = 1'b1; end
    else        begin din_b = d; wr_en_b = 1'b1; end
    @(negedge CLK);
    if (w == 0) wr_en_a = 1'b0; else wr_en_b = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
    rx_drv_b = 1'b0;
    repeat (BIT) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx_drv_b = d[i];
      repeat (BIT) @(negedge CLK);
    end
    rx_drv_b = ~(^d) ^ flip;
    repeat (BIT) @(negedge CLK);
    rx_drv_b = stop;
    repeat (BIT) @(negedge CLK);
    rx_drv_b = 1'b1;
    repeat (BIT) @(negedge CLK);
  endtask

  task automatic wait_tx_low(input int w);
    int t = 0;
    while (get_tx(w) !== 1'b0 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 20) fail("tx_start_timeout");
  endtask

  task automatic wait_idle();
    int t = 0;
    while (t < 20000 && !(q_txa.size() == 0 && q_txb.size() == 0 && q_rxa.size() == 0 &&
           q_rxb.size() == 0 && !tx_busy_a && !tx_busy_b && rx_empty_a && rx_empty_b)) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 20000) fail("drain_timeout");
    repeat (10) @(negedge CLK);
  endtask

  task automatic clear_b();
    @(negedge CLK);
    err_clr_b = 1'b1;
    @(negedge CLK);
    err_clr_b = 1'b0;
  endtask

  task automatic flags_clear(input string tag);
    chk1({tag, "_perr_a"}, perr_a, 1'b0);
    chk1({tag, "_ferr_a"}, ferr_a, 1'b0);
    chk1({tag, "_ovr_a"}, ovr_a, 1'b0);
    chk1({tag, "_perr_b"}, perr_b, 1'b0);
    chk1({tag, "_ferr_b"}, ferr_b, 1'b0);
    chk1({tag, "_ovr_b"}, ovr_b, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr;
    logic [7:0] v;
    RST_N = 1'b0;
    din_a = '0; wr_en_a = 1'b0; err_clr_a = 1'b0;
    din_b = '0; wr_en_b = 1'b0; err_clr_b = 1'b0;
    loop_b = 1'b1; rx_drv_b = 1'b1;
    repeat (3) @(negedge CLK);
    chk1("rst_tx_a", tx_a, 1'b1);
    chk1("rst_tx_b", tx_b, 1'b1);
    chk1("rst_busy_b", tx_busy_b, 1'b0);
    chk1("rst_full_b", tx_full_b, 1'b0);
    chk1("rst_empty_b", rx_empty_b, 1'b1);
    chk("rst_dout_a", dout_a, 8'h00);
    chk("rst_dout_b", dout_b, 8'h00);
    flags_clear("rst");
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    // Exact waveform of 0xA5 on the 8N1 instance.
    q_txa.push_back(8'hA5); q_rxa.push_back(8'hA5);
    wr(0, 8'hA5);
    wait_tx_low(0);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      chk1("wave_bit_begin", tx_a, fr[k]);
      repeat (BIT - 1) @(negedge CLK);
      chk1("wave_bit_end", tx_a, fr[k]);
      if (k == 9) chk1("wave_busy_639", tx_busy_a, 1'b1);
      @(negedge CLK);
    end
    chk1("wave_busy_640", tx_busy_a, 1'b0);
    chk1("wave_idle_640", tx_a, 1'b1);
    wait_idle();

    // Back-to-back loopback words, then randomised traffic on both instances.
    foreach (fr[i]) ;
    v = 8'h00; q_txb.push_back(v); q_rxb.push_back(v); wr(1, v);
    v = 8'hFF; q_txb.push_back(v); q_rxb.push_back(v); wr(1, v);
    v = 8'h3C; q_txb.push_back(v); q_rxb.push_back(v); wr(1, v);
    wait_idle();
    flags_clear("loop3");
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] r;
          r = 8'($urandom);
          repeat ($urandom_range(0, 100)) @(negedge CLK);
          q_txa.push_back(r); q_rxa.push_back(r);
          wr(0, r);
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          logic [7:0] r;
          r = 8'($urandom);
          repeat ($urandom_range(200, 900)) @(negedge CLK);
          chk1("rand_not_full_b", tx_full_b, 1'b0);
          q_txb.push_back(r); q_rxb.push_back(r);
          wr(1, r);
        end
      end
    join
    wait_idle();
    flags_clear("rand");

    // TX FIFO fill: one word in the shifter plus four queued, sixth dropped.
    q_txb.push_back(8'h11); q_rxb.push_back(8'h11);
    wr(1, 8'h11);
    wait_tx_low(1);
    for (int i = 2; i <= 6; i++) begin
      v = 8'(i * 8'h11);
      if (i <= 5) begin q_txb.push_back(v); q_rxb.push_back(v); end
      wr(1, v);
      if (i == 4) chk1("full_after_4", tx_full_b, 1'b0);
      if (i >= 5) chk1("full_after_5", tx_full_b, 1'b1);
    end
    wait_idle();

    // Directly driven receiver frames.
    loop_b = 1'b0;
    q_rxb.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b1);
    chk1("perr_set", perr_b, 1'b1);
    chk1("perr_no_ferr", ferr_b, 1'b0);
    clear_b();
    chk1("perr_cleared", perr_b, 1'b0);
    q_rxb.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b0);
    chk1("ferr_set", ferr_b, 1'b1);
    chk1("ferr_no_perr", perr_b, 1'b0);
    clear_b();
    chk1("ferr_cleared", ferr_b, 1'b0);
    rx_drv_b = 1'b0;
    repeat (2 * CPT) @(negedge CLK);
    rx_drv_b = 1'b1;
    repeat (200) @(negedge CLK);
    chk1("glitch_no_push", rx_empty_b, 1'b1);
    q_rxb.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_idle();
    flags_clear("glitch");

    // Overrun: five frames into a four-entry FIFO with nobody reading.
    mon_en_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q_rxb.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b1);
    end
    chk1("ovr_set", ovr_b, 1'b1);
    chk1("ovr_not_empty", rx_empty_b, 1'b0);
    chk1("ovr_no_perr", perr_b, 1'b0);
    mon_en_b = 1'b1;
    wait_idle();
    clear_b();
    chk1("ovr_cleared", ovr_b, 1'b0);

    // Reset in the middle of a data bit, then a clean frame afterwards.
    loop_b = 1'b1;
    q_txb.push_back(8'h96); q_rxb.push_back(8'h96);
    wr(1, 8'h96);
    wait_tx_low(1);
    repeat (BIT + 20) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    gen_b++;
    q_txb.delete(); q_rxb.delete();
    #1;
    chk1("rst_mid_tx", tx_b, 1'b1);
    chk1("rst_mid_busy", tx_busy_b, 1'b0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (900) @(negedge CLK);
    q_txb.push_back(8'h69); q_rxb.push_back(8'h69);
    wr(1, 8'h69);
    wait_idle();
    flags_clear("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
